regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between two producers.
- The primary producer is the in-order pipeline writeback (MEM/WB), which always wins.
- The secondary producer is a multi-cycle unit (divider / late load) using a valid/ready handshake, buffered in a small FIFO.
- The block drops stale buffered results on WAW, reports pending targets for hazard logic, and raises a stall request when the secondary path is starved.

Parameters:
DEPTH, 2, secondary FIFO entries (power of 2, ≥2)
MAX_WAIT, 4, consecutive blocked cycles before stall_req asserts
AW, 5, register address width
DW, 32, data width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
p_we  in  1  primary write enable
p_waddr  in  AW  primary destination
p_wdata  in  DW  primary data
s_valid  in  1  secondary result valid
s_ready  out  1  secondary may push
s_waddr  in  AW  secondary destination
s_wdata  in  DW  secondary data
rf_we  out  1  regfile write enable
rf_waddr  out  AW  regfile write address
rf_wdata  out  DW  regfile write data
chk_addr  in  AW  hazard query address
chk_busy  out  1  chk_addr has a live buffered write
stall_req  out  1  request that the pipeline suppress p_we
fifo_cnt  out  log2(DEPTH)+1  entries held, live or killed

Behaviour:
- **Reset (rst=0, async):**
  - FIFO is emptied: pointers, count and kill bits cleared.
  - wait_cnt is cleared; stall_req=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, s_ready=0, chk_busy=0, fifo_cnt=0.
  - Any in-flight entries are lost; the secondary unit is reset by the same rst.
- **Primary grant:** p_we=1 and p_waddr≠0 is a primary grant. rf_* pass p_* through combinationally in the same cycle, so the primary path has zero latency. p_we with p_waddr=0 is ignored.
- **Secondary grant:** when there is no primary grant and the FIFO head is live, rf_* present the head (rf_we=1) and the head pops at the clock edge.
- **Secondary latency:** secondary results always traverse the FIFO; minimum latency is 1 cycle from push to write.
- **Idle:** when there is no grant, rf_we=0 and rf_waddr/rf_wdata=0.
- **Push:**
  - s_ready = (fifo_cnt < DEPTH). It is independent of a same-cycle pop, so there is no combinational path from p_we to s_ready.
  - A push occurs when s_valid & s_ready.
  - s_waddr=0 is accepted and discarded (not stored).
- **WAW kill:** on a primary grant to address A:
  - Every live entry with addr A is marked killed.
  - A same-cycle push with s_waddr=A is stored already killed, because the secondary result is older than the pipeline write.
- **Killed head:** pops without writing, in any cycle including primary-grant cycles. Only one pop per cycle.
- **Simultaneous push and pop:** allowed; the count is unchanged. When full, no push occurs since s_ready=0.
- **Pointer wrap:** pointers wrap modulo DEPTH.
- **chk_busy:** 1 iff chk_addr≠0 and any live entry has addr==chk_addr. Combinational. It does not include a same-cycle incoming push.
- **Starvation:**
  - wait_cnt increments each cycle the head is live and a primary grant occurs, saturating at MAX_WAIT.
  - wait_cnt clears on a head pop or when the FIFO is empty.
  - stall_req is a register: set at the edge where wait_cnt reaches MAX_WAIT, cleared at the edge where the live head is written.
  - stall_req is advisory: if p_we remains asserted, primary still wins.
- **fifo_cnt** reflects the registered state.

Test Plan:
- Primary only: p_we=1, p_waddr=3, p_wdata=0x11 → rf_we=1, rf_waddr=3, rf_wdata=0x11 in the same cycle. p_waddr=0 → rf_we=0.
- Secondary idle path: s_valid=1, s_waddr=7, s_wdata=0xAB for one cycle with p_we=0 → next cycle rf_we=1, rf_waddr=7, rf_wdata=0xAB; fifo_cnt goes 1 then 0.
- Full/backpressure: push 2 entries (addr 4, 5) while p_we=1 to addr 9 → fifo_cnt=2, s_ready=0, third s_valid held. Drop p_we → writes 4, then 5, in order; s_ready returns to 1 the cycle after the first pop.
- WAW kill: buffer addr 6 = 0x66, then primary writes addr 6 = 0x77 → chk_busy(6) goes 1→0. After p_we drops, no write of 0x66 occurs; fifo_cnt drains to 0. Also cover a same-cycle push of addr 6 alongside primary addr 6.
- Starvation: buffer addr 8, hold p_we=1 to addr 2 → stall_req=1 after MAX_WAIT=4 blocked cycles. Drop p_we → addr 8 written and stall_req=0 the following cycle.
- Async reset mid-operation: with 2 entries buffered and stall_req=1, pulse rst=0 between clock edges → all outputs 0 immediately. After release, no stale write occurs; s_ready=1.

Source files
------------

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle between the pipeline/secondary producers and the regfile write arbiter.
// Carries primary/secondary write requests, the regfile write port, hazard query and status.
interface regfile_wb_arbiter_if #(
  parameter int DEPTH = 2,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          p_we;
  logic [AW-1:0] p_waddr;
  logic [DW-1:0] p_wdata;
  logic          s_valid;
  logic          s_ready;
  logic [AW-1:0] s_waddr;
  logic [DW-1:0] s_wdata;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] chk_addr;
  logic          chk_busy;
  logic          stall_req;
  logic [CW-1:0] fifo_cnt;

  modport master (
    output p_we, p_waddr, p_wdata,
    output s_valid, s_waddr, s_wdata,
    output chk_addr,
    input  s_ready, rf_we, rf_waddr, rf_wdata,
    input  chk_busy, stall_req, fifo_cnt
  );

  modport slave (
    input  p_we, p_waddr, p_wdata,
    input  s_valid, s_waddr, s_wdata,
    input  chk_addr,
    output s_ready, rf_we, rf_waddr, rf_wdata,
    output chk_busy, stall_req, fifo_cnt
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the regfile write port: pipeline writeback wins, multi-cycle results buffer in a FIFO.
// Ports: clk, rst (async active-low), bus (slave modport: p_*, s_*, rf_*, chk_*, stall_req, fifo_cnt).
module regfile_wb_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int AW       = 5,
  parameter int DW       = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);

  logic [AW-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_kill;
  logic [PW-1:0]    r_wp;
  logic [PW-1:0]    r_rp;
  logic [CW-1:0]    r_cnt;
  logic [WW-1:0]    r_wait;
  logic             r_stall;

  logic             w_pg;
  logic             w_empty;
  logic             w_head_live;
  logic             w_sg;
  logic             w_pop;
  logic             w_rdy;
  logic             w_push;
  logic             w_push_kill;
  logic             w_wr_p;
  logic             w_wr_s;
  logic             w_busy;
  logic [PW-1:0]    w_off;
  logic [DEPTH-1:0] w_occ;
  logic [DEPTH-1:0] w_kill_nxt;
  logic [WW-1:0]    w_wait_nxt;

  assign w_pg        = bus.p_we && (bus.p_waddr != '0);
  assign w_empty     = (r_cnt == '0);
  assign w_head_live = !w_empty && !r_kill[r_rp];
  assign w_sg        = !w_pg && w_head_live;
  // A killed head drains even under a primary grant
  assign w_pop       = !w_empty && (r_kill[r_rp] || !w_pg);
  assign w_rdy       = (r_cnt < CW'(DEPTH));
  assign w_push      = bus.s_valid && w_rdy && (bus.s_waddr != '0);
  // Secondary result is older than the pipeline write to the same reg
  assign w_push_kill = w_pg && (bus.s_waddr == bus.p_waddr);

  assign w_wr_p = rst && w_pg;
  assign w_wr_s = rst && w_sg;

  always_comb begin
    w_occ  = '0;
    w_busy = 1'b0;
    w_off  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_off    = PW'(i) - r_rp;
      w_occ[i] = CW'(w_off) < r_cnt;
      if (w_occ[i] && !r_kill[i] && (r_addr[i] == bus.chk_addr))
        w_busy = 1'b1;
    end
  end

  always_comb begin
    w_kill_nxt = r_kill;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_pg && w_occ[i] && (r_addr[i] == bus.p_waddr))
        w_kill_nxt[i] = 1'b1;
    end
    if (w_push)
      w_kill_nxt[r_wp] = w_push_kill;
  end

  always_comb begin
    w_wait_nxt = r_wait;
    if (w_empty || w_pop)
      w_wait_nxt = '0;
    else if (w_head_live && w_pg && (r_wait != WW'(MAX_WAIT)))
      w_wait_nxt = r_wait + WW'(1);
  end

  always_comb begin
    bus.rf_we    = 1'b0;
    bus.rf_waddr = '0;
    bus.rf_wdata = '0;
    unique case (1'b1)
      w_wr_p: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = bus.p_waddr;
        bus.rf_wdata = bus.p_wdata;
      end
      w_wr_s: begin
        bus.rf_we    = 1'b1;
        bus.rf_waddr = r_addr[r_rp];
        bus.rf_wdata = r_data[r_rp];
      end
      default: ;
    endcase
  end

  // Gated by rst so outputs drop as soon as reset asserts
  assign bus.s_ready   = rst && w_rdy;
  assign bus.chk_busy  = rst && (bus.chk_addr != '0) && w_busy;
  assign bus.stall_req = r_stall;
  assign bus.fifo_cnt  = r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_kill  <= '0;
      r_wait  <= '0;
      r_stall <= 1'b0;
    end else begin
      r_kill <= w_kill_nxt;
      r_wait <= w_wait_nxt;
      if (w_push)
        r_wp <= r_wp + PW'(1);
      if (w_pop)
        r_rp <= r_rp + PW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: ;
      endcase
      if (w_wait_nxt == WW'(MAX_WAIT))
        r_stall <= 1'b1;
      else if (w_sg || w_empty)
        r_stall <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wp] <= bus.s_waddr;
      r_data[r_wp] <= bus.s_wdata;
    end
  end
endmodule
